// File: rtl/to_lower_stream.sv
// to_lower_stream: streaming ASCII uppercase-to-lowercase converter with an
// output FIFO. Bytes are accepted on a valid/ready input, and 'A'..'Z' are
// folded to 'a'..'z' as they are written. They leave through a valid/ready
// output that drives the FIFO head straight out.
//
// Optional feature macro: TO_LOWER_COUNT_EN
//   When it is defined, a COUNT_W-bit conv_count port and register are added.
//   The register counts every accepted byte that was uppercase. It wraps
//   around and is cleared only by rst.
//
// Pointers are $clog2(DEPTH)+1 bits wide. The extra MSB tells a full FIFO
// apart from an empty one. Every status output is decoded from the registered
// pointers alone, so no output has a combinational path from in_valid or
// out_ready.
module to_lower_stream #(
  parameter int DEPTH   = 4,
  parameter int COUNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] level
`ifdef TO_LOWER_COUNT_EN
  ,
  output logic [COUNT_W-1:0]     conv_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  // Pointer state, with next-state values
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;

  // Storage (no reset; only entries that are known to be written are read)
  logic [7:0]       mem_q [DEPTH];

  // Datapath and handshake decode
  logic             is_upper;
  logic [7:0]       conv_byte;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] entry_we;

  // Fold an uppercase letter to lowercase; leave every other byte untouched
  always_comb begin
    is_upper  = (in_data >= 8'h41) && (in_data <= 8'h5A);
    conv_byte = is_upper ? (in_data + 8'h20) : in_data;
  end

  // Status flags come only from the registered pointers
  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  end

  // A flush cancels any transfer that happens in the same cycle
  always_comb begin
    push = in_valid && !full && !flush;
    pop  = !empty && out_ready && !flush;
  end

  // Next pointers: a flush wins; otherwise each pointer advances independently
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_d = rptr_q + 1'b1;
      end
    end
  end

  // Pointer registers; reset asynchronously to the empty state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Decode one write strobe for each storage entry
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
      assign entry_we[gi] = push && (wptr_q[AW-1:0] == AW'(gi));
    end
  endgenerate

  // Store the converted byte in the entry that the write pointer addresses
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_we[i]) begin
        mem_q[i] <= conv_byte;
      end
    end
  end

  // Drive the head entry out; force it to zero while empty so it is never unknown
  always_comb begin
    out_valid = !empty;
    in_ready  = !full;
    level     = wptr_q - rptr_q;
    out_data  = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
  end

`ifdef TO_LOWER_COUNT_EN
  logic [COUNT_W-1:0] count_q, count_d;

  // Count accepted uppercase bytes; a flush cancels the push, so it cancels the count too
  always_comb begin
    count_d = count_q;
    if (push && is_upper) begin
      count_d = count_q + 1'b1;
    end
  end

  // Conversion counter; cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign conv_count = count_q;
`endif

endmodule

// File: tb/tb_to_lower_stream.sv
// Testbench for to_lower_stream. A queue-based reference model predicts every
// output on every cycle. The stimulus is directed scenarios plus a randomised
// phase. If TO_LOWER_COUNT_EN is defined, conv_count is also checked.
module tb_to_lower_stream;

  localparam int DEPTH   = 4;
  localparam int COUNT_W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       flush;
  logic [2:0] level;
`ifdef TO_LOWER_COUNT_EN
  logic [COUNT_W-1:0] conv_count;
`endif

  to_lower_stream #(
    .DEPTH   (DEPTH),
    .COUNT_W (COUNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .level     (level)
`ifdef TO_LOWER_COUNT_EN
    ,
    .conv_count(conv_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: FIFO contents as a queue, plus the number of uppercase pushes
  logic [7:0]  model_q [$];
  int unsigned model_count;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [7:0] ref_lower(input logic [7:0] b);
    if (b >= "A" && b <= "Z") return b - "A" + "a";
    return b;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare every visible output against the model's prediction
  task automatic compare_outputs();
    check_eq("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    check_eq("in_ready",  32'(in_ready),  32'(model_q.size() < DEPTH));
    check_eq("level",     32'(level),     32'(model_q.size()));
    if (model_q.size() != 0) check_eq("out_data", 32'(out_data), 32'(model_q[0]));
`ifdef TO_LOWER_COUNT_EN
    check_eq("conv_count", 32'(conv_count), model_count % (1 << COUNT_W));
`endif
  endtask

  // One clock cycle: check the outputs, predict the transfers, advance the model
  task automatic step(output bit acc);
    bit pop;
    compare_outputs();
    acc = in_valid && (model_q.size() < DEPTH) && !flush;
    pop = (model_q.size() != 0) && out_ready && !flush;
    @(posedge clk);
    #1;
    if (flush) begin
      model_q.delete();
      $display("flush");
    end else begin
      if (pop) begin
        $display("pop  %02h", model_q[0]);
        void'(model_q.pop_front());
      end
      if (acc) begin
        model_q.push_back(ref_lower(in_data));
        if (in_data >= "A" && in_data <= "Z") model_count++;
      end
    end
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  // Assert reset asynchronously, check the outputs before any clock edge, then release it
  task automatic apply_reset(input string tag);
    #3;
    rst = 1'b1;
    #1;
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_level"}, 32'(level), 32'd0);
    check_eq({tag, "_ready"}, 32'(in_ready), 32'd1);
`ifdef TO_LOWER_COUNT_EN
    check_eq({tag, "_count"}, 32'(conv_count), 32'd0);
`endif
    model_q.delete();
    model_count = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic push_n(input logic [7:0] b, input int n);
    bit acc;
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = b + 8'(i);
      step(acc);
      check_eq("push_n_acc", 32'(acc), 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH && model_q.size() != 0; i++) step(acc);
    check_eq("drain_level", 32'(level), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] hello [5];
    logic [7:0] hello_lc [5];
    logic [7:0] seen [$];
    int         idx;
    bit         acc;
    int unsigned saved_count;

    hello    = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    hello_lc = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    idle_inputs();
    model_count = 0;
    rst = 1'b1;
    #1;
    check_eq("por_data_known", 32'($isunknown(out_data)), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    compare_outputs();

    // Reset in the middle of a stream
    push_n(8'h41, 2);
    apply_reset("midrst");
    in_valid = 1'b1; in_data = 8'h43;
    step(acc);
    in_valid = 1'b0;
    check_eq("post_rst_data", 32'(out_data), 32'h63);
    check_eq("post_rst_valid", 32'(out_valid), 32'd1);
    drain();

    // Sweep every byte value with the sink always ready
    apply_reset("sweep_rst");
    out_ready = 1'b1;
    for (int b = 0; b < 256; b++) begin
      in_valid = 1'b1;
      in_data  = 8'(b);
      step(acc);
      check_eq("sweep_acc", 32'(acc), 32'd1);
    end
    in_valid = 1'b0;
`ifdef TO_LOWER_COUNT_EN
    check_eq("sweep_count", 32'(conv_count), 32'(26 % (1 << COUNT_W)));
`endif
    drain();

    // Fill against backpressure, then drain "hello" in order
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (idx < 5);
      in_data  = hello[idx < 5 ? idx : 4];
      step(acc);
      if (acc) idx++;
    end
    check_eq("hello_accepted", 32'(idx), 32'd4);
    check_eq("hello_full_ready", 32'(in_ready), 32'd0);
    check_eq("hello_full_level", 32'(level), 32'd4);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && !(idx == 5 && model_q.size() == 0); c++) begin
      in_valid = (idx < 5);
      in_data  = hello[idx < 5 ? idx : 4];
      if (out_valid) seen.push_back(out_data);
      step(acc);
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check_eq("hello_len", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5 && i < seen.size(); i++) check_eq("hello_byte", 32'(seen[i]), 32'(hello_lc[i]));
    drain();

    // Push and pop together at level 2, then offer a push while full with a pop in the same cycle
    push_n(8'h41, 2);
    in_valid = 1'b1; in_data = 8'h43; out_ready = 1'b1;
    step(acc);
    check_eq("simul_level", 32'(level), 32'd2);
    in_valid = 1'b0;
    drain();
    push_n(8'h50, 4);
    in_valid = 1'b1; in_data = 8'h54; out_ready = 1'b1;
    step(acc);
    check_eq("full_pop_acc", 32'(acc), 32'd0);
    check_eq("full_pop_level", 32'(level), 32'd3);
    in_valid = 1'b0;
    drain();

    // Flush at level 3 while both sides are active
    push_n(8'h4A, 3);
    saved_count = model_count;
    in_valid = 1'b1; in_data = 8'h4D; out_ready = 1'b1; flush = 1'b1;
    step(acc);
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_level", 32'(level), 32'd0);
    check_eq("flush_valid", 32'(out_valid), 32'd0);
    check_eq("flush_count_model", model_count, saved_count);
`ifdef TO_LOWER_COUNT_EN
    check_eq("flush_count", 32'(conv_count), 32'(saved_count % (1 << COUNT_W)));
`endif

    // Randomised traffic; the source holds its byte until it is accepted
    in_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom_range(8'h3E, 8'h5E));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      step(acc);
    end
    idle_inputs();
    drain();

    // The counter wraps after 2^COUNT_W uppercase pushes
    apply_reset("wrap_rst");
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_data = 8'h5A;
      step(acc);
    end
    in_valid = 1'b0;
    check_eq("wrap_model", model_count % (1 << COUNT_W), 32'd1);
`ifdef TO_LOWER_COUNT_EN
    check_eq("wrap_count", 32'(conv_count), 32'd1);
`endif
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/to_lower_stream.md
# to_lower_stream

Streaming ASCII lowercase converter: accepts bytes on a valid/ready input, maps 'A'–'Z' (0x41–0x5A) to 'a'–'z' (0x61–0x7A), and delivers them through an internal FIFO on a valid/ready output. It is the inverse-direction companion to the combinational uppercase converter and sits on the character datapath between a byte source (UART RX / text buffer) and a consumer that applies backpressure. An optional counter reports how many bytes were actually modified.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2.
- COUNT_W, 16, width of conversion counter (used only with TO_LOWER_COUNT_EN).
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  8  input byte.
- in_valid  input  1  source has a byte.
- in_ready  output  1  block can accept; equals !full.
- out_data  output  8  converted byte at FIFO head.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  sink accepts head byte.
- flush  input  1  synchronous clear of FIFO contents.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- conv_count  output  COUNT_W  bytes modified (present only with TO_LOWER_COUNT_EN).

## Operation
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- Conversion applied on write: stored = in_data + 0x20 iff 0x41 ≤ in_data ≤ 0x5A; otherwise stored unchanged (lowercase, digits, punctuation, controls, all bytes ≥ 0x80 untouched).
- Storage: DEPTH×8 array, write pointer, read pointer, each $clog2(DEPTH)+1 bits; extra MSB distinguishes full from empty. Pointers wrap modulo 2·DEPTH.
- empty = (wptr == rptr); full = low bits equal and MSBs differ. level = wptr − rptr.
- out_data = array[rptr low bits]; valid only while out_valid; value when empty is don't-care but must not be X after reset (array contents reset-free; bench checks out_data only under out_valid).
- Simultaneous push and pop when neither empty nor full: both occur, level unchanged.
- Full: in_ready = 0; no push even if a pop occurs that cycle (no pass-through).
- Empty: out_valid = 0; a push that cycle becomes visible the next cycle (no combinational bypass).
- flush: next edge sets wptr = rptr = 0; any push or pop in the same cycle is discarded; flush overrides everything except rst.
- Source must hold in_data stable while in_valid && !in_ready; sink sees out_data stable while out_valid && !out_ready.

## Timing
- Reset (async assert, any time, including mid-stream): wptr = rptr = 0, out_valid = 0, in_ready = 1, level = 0, conv_count = 0. Outputs reach these values without a clock edge.
- Latency: byte pushed at edge N appears on out_data with out_valid = 1 after edge N (available in cycle N+1).
- Throughput: one byte per cycle sustained when out_ready held high.
- in_ready, out_valid, level are decoded from registered pointers only; no combinational path from in_valid or out_ready to any output.

## Configuration
- TO_LOWER_COUNT_EN defined: conv_count port and COUNT_W-bit register exist; increments by 1 on every push whose input byte was in 0x41–0x5A; wraps to 0 after 2^COUNT_W − 1; cleared by rst only (flush does not clear it).
- Undefined: conv_count port and register absent; all other behaviour identical.

## Test plan
- Reset mid-stream: push 0x41,0x42, assert rst between edges -> out_valid = 0, level = 0, in_ready = 1 immediately; after release, first new push 0x43 -> out 0x63.
- Mapping sweep, out_ready = 1: push 0x00..0xFF -> out equals input except 0x41..0x5A become 0x61..0x7A; 0x40, 0x5B, 0x61, 0xC1 unchanged; conv_count = 26 (with macro).
- Fill/backpressure, DEPTH = 4, out_ready = 0: push "HELLO" -> first four accepted, in_ready = 0, level = 4, 'O' held; then out_ready = 1 -> "hell" then "o" in order.
- Simultaneous push/pop at level 2 -> level stays 2, data order preserved; push while full with pop same cycle -> push rejected, level = 3.
- Flush with in_valid and out_ready high at level 3 -> next cycle level = 0, out_valid = 0, neither byte transferred; conv_count unchanged.
- Counter wrap, COUNT_W = 4, macro defined: push 17 bytes of 0x5A -> conv_count = 1; macro undefined build elaborates with no conv_count port.
